// File: rtl/ext_mem_arb.sv
// ext_mem_arb: round-robin arbiter merging N native-bus masters onto the
// single L2 front-end port, with deferred L2 force-invalidate sequencing.
// The granted request is registered so the L2 sees stable fields. An
// invalidate is only issued from IDLE, so it never overlaps an L2 access.
module ext_mem_arb #(
    parameter  int ADDR_W    = 24,
    parameter  int DATA_W    = 32,
    parameter  int N_MASTERS = 2,
    localparam int STRB_W    = DATA_W / 8,
    localparam int REQ_W     = 1 + ADDR_W + DATA_W + STRB_W,
    localparam int RESP_W    = DATA_W + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_MASTERS*REQ_W-1:0]  m_req,
    output logic [N_MASTERS*RESP_W-1:0] m_resp,
    output logic [REQ_W-1:0]            s_req,
    input  logic [RESP_W-1:0]           s_resp,
    input  logic                        inv_in,
    output logic                        inv_out
);

    localparam int PTR_W = $clog2(N_MASTERS);

    // Field offsets inside one request slice {valid, addr, wdata, wstrb}
    localparam int WDATA_LSB = STRB_W;
    localparam int ADDR_LSB  = STRB_W + DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INV  = 2'd1,
        ST_BUSY = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PTR_W-1:0]    r_last;
    logic [PTR_W-1:0]    r_gnt;
    logic                r_inv_pend;
    logic                r_s_valid;
    logic [ADDR_W-1:0]   r_s_addr;
    logic [DATA_W-1:0]   r_s_wdata;
    logic [STRB_W-1:0]   r_s_wstrb;

    logic [N_MASTERS-1:0] w_valid;
    logic                 w_hi_any;
    logic                 w_lo_any;
    logic [PTR_W-1:0]     w_hi;
    logic [PTR_W-1:0]     w_lo;
    logic                 w_any;
    logic [PTR_W-1:0]     w_gnt;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [DATA_W-1:0]    w_sel_wdata;
    logic [STRB_W-1:0]    w_sel_wstrb;
    logic                 w_do_grant;
    logic                 w_done;
    logic                 w_inv_out;
    logic [N_MASTERS*RESP_W-1:0] w_m_resp;

    // Gather the valid bit of every master slice
    always_comb begin
        w_valid = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            w_valid[i] = m_req[i*REQ_W + REQ_W - 1];
        end
    end

    // Round-robin pick: lowest valid index above r_last wins, otherwise the
    // lowest valid index at or below it (wraps without modulo arithmetic, so a
    // non-power-of-2 master count can never yield an out-of-range index)
    always_comb begin
        w_hi_any = 1'b0;
        w_lo_any = 1'b0;
        w_hi     = '0;
        w_lo     = '0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            if (w_valid[i]) begin
                if (i > int'(r_last)) begin
                    w_hi_any = 1'b1;
                    w_hi     = PTR_W'(i);
                end else begin
                    w_lo_any = 1'b1;
                    w_lo     = PTR_W'(i);
                end
            end
        end
        w_any = w_hi_any | w_lo_any;
        w_gnt = w_hi_any ? w_hi : w_lo;
    end

    // Select the fields of the master chosen by the arbiter
    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_wstrb = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (PTR_W'(i) == w_gnt) begin
                w_sel_addr  = m_req[i*REQ_W + ADDR_LSB  +: ADDR_W];
                w_sel_wdata = m_req[i*REQ_W + WDATA_LSB +: DATA_W];
                w_sel_wstrb = m_req[i*REQ_W             +: STRB_W];
            end
        end
    end

    // FSM next-state and strobes; a pending invalidate takes priority over
    // arbitration so it slots into the gap between L2 accesses
    always_comb begin
        w_state_nxt = r_state;
        w_do_grant  = 1'b0;
        w_done      = 1'b0;
        w_inv_out   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_inv_pend) begin
                    w_state_nxt = ST_INV;
                end else if (w_any) begin
                    w_do_grant  = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_INV: begin
                w_inv_out   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            ST_BUSY: begin
                if (s_resp[0]) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Invalidate latch: a new pulse always wins over the clear in INV
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inv_pend <= 1'b0;
        end else if (inv_in) begin
            r_inv_pend <= 1'b1;
        end else if (r_state == ST_INV) begin
            r_inv_pend <= 1'b0;
        end
    end

    // Grant bookkeeping; r_last only advances when a transaction completes,
    // so an abandoned or reset transaction does not move the pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt  <= '0;
            r_last <= PTR_W'(N_MASTERS - 1);
        end else begin
            if (w_do_grant) begin
                r_gnt <= w_gnt;
            end
            if (w_done) begin
                r_last <= r_gnt;
            end
        end
    end

    // Registered L2 request, held constant for the whole access
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_valid <= 1'b0;
            r_s_addr  <= '0;
            r_s_wdata <= '0;
            r_s_wstrb <= '0;
        end else if (w_do_grant) begin
            r_s_valid <= 1'b1;
            r_s_addr  <= w_sel_addr;
            r_s_wdata <= w_sel_wdata;
            r_s_wstrb <= w_sel_wstrb;
        end else if (w_done) begin
            r_s_valid <= 1'b0;
        end
    end

    // Route the L2 response to the granted master in the same cycle; a
    // reset cycle suppresses it so an abandoned access delivers nothing
    always_comb begin
        w_m_resp = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if ((r_state == ST_BUSY) && s_resp[0] && !rst && (PTR_W'(i) == r_gnt)) begin
                w_m_resp[i*RESP_W +: RESP_W] = s_resp;
            end
        end
    end

    assign m_resp  = w_m_resp;
    assign s_req   = {r_s_valid, r_s_addr, r_s_wdata, r_s_wstrb};
    assign inv_out = w_inv_out;

endmodule

// File: doc/ext_mem_arb.md
Name: ext_mem_arb

Overview:
- Round-robin arbiter that merges N native-bus masters (instruction and data cache back-ends) into the single native front-end of the L2 cache inside the external-memory subsystem.
- Registers the granted request so the L2 sees a stable, glitch-free request.
- Sequences L2 force-invalidate: invalidate is issued only while no L2 access is in flight.

Parameters:
- ADDR_W, 24: byte address width of master and slave buses.
- DATA_W, 32: data width; wstrb width is DATA_W/8.
- N_MASTERS, 2: number of masters, legal range 2..8.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- m_req  in  N_MASTERS*REQ_W  master requests, master i at slice [i*REQ_W +: REQ_W]; REQ_W = 1+ADDR_W+DATA_W+DATA_W/8; each slice is {valid, addr, wdata, wstrb}, MSB first.
- m_resp  out  N_MASTERS*RESP_W  master responses; RESP_W = DATA_W+1; each slice is {rdata, ready}.
- s_req  out  REQ_W  request to L2, same field format.
- s_resp  in  RESP_W  L2 response {rdata, ready}.
- inv_in  in  1  invalidate request pulse from the data cache.
- inv_out  out  1  force-invalidate strobe to the L2.

Behaviour:
- Bus rule: a master holds valid and its fields until it sees ready=1; ready is a 1-cycle pulse, and rdata is valid only in that cycle. wstrb=0 means read.
- Reset (synchronous): state=IDLE, last_grant=N_MASTERS-1 (so master 0 wins first), s_req=0, inv_pend=0, inv_out=0, and all m_resp ready=0 and rdata=0.
- FSM states: IDLE, INV, BUSY.
- IDLE, inv_pend=1: go to INV. No grant is made this cycle, even if requests are pending.
- IDLE, inv_pend=0 and any valid: grant g = first valid index searching last_grant+1, last_grant+2, ... modulo N_MASTERS. Capture master g's addr/wdata/wstrb into the s_req register, store g, go to BUSY.
- IDLE, nothing pending: stay.
- INV: inv_out=1 for exactly this one cycle. Clear inv_pend, unless inv_in=1 in this same cycle, in which case inv_pend stays 1. Go to IDLE.
- BUSY: s_req.valid=1 with the captured fields, held constant.
- BUSY, s_resp.ready=1: m_resp[g] = {s_resp.rdata, 1} combinationally in the same cycle. On the next edge: s_req.valid=0, last_grant=g, state=IDLE.
- Non-granted masters, and all masters outside BUSY: ready=0, rdata=0.
- inv_in is latched into inv_pend on any cycle in any state. An invalidate therefore never overlaps an L2 access.
- Latency: request sampled in cycle t → s_req.valid in cycle t+1. If the slave answers in cycle t+1+k, the master sees ready in t+1+k.
- Throughput: one transaction per (slave latency + 2) cycles; the IDLE cycle between transactions is mandatory.
- A master that drops valid while granted (protocol violation): the transaction still completes and the response pulse is still driven.
- A master whose valid rises during BUSY waits for the next IDLE arbitration.
- Round-robin fairness: a continuously requesting master is granted within N_MASTERS grants.
- Reset during BUSY: the transaction is abandoned. s_req.valid=0 from the next cycle, no response is delivered, and arbitration restarts at master 0.
- Pointer width: clog2(N_MASTERS). Modulo wrap from N_MASTERS-1 to 0; non-power-of-2 N must not select a nonexistent index.

Test Plan:
- Single read: m0 valid, addr 0x000040, wstrb 0 at cycle 0 → s_req valid cycle 1 with addr 0x000040. Slave ready at cycle 3 with rdata 0xDEADBEEF → m0 ready=1, rdata 0xDEADBEEF in cycle 3; s_req.valid=0 in cycle 4; m1 ready stays 0.
- Contention: m0 and m1 both valid continuously from reset, slave ready 1 cycle after valid → grants 0,1,0,1; each transaction occupies 3 cycles.
- Write pass-through: m1 addr 0x000100, wdata 0x12345678, wstrb 0xF → s_req fields exact; m1 ready only on s_resp.ready.
- Invalidate deferral: inv_in pulse during BUSY with m0 also requesting → inv_out=1 for one cycle in the cycle after BUSY ends; m0 is granted the cycle after that; inv_out is never high while s_req.valid=1.
- Reset mid-transaction: rst=1 while BUSY awaiting ready → s_req.valid=0 the next cycle and no m ready pulse. After release, with m0 and m1 requesting, m0 is granted first.
- N_MASTERS=3, last_grant=1, m1 and m2 valid → grant 2 then 1; with m0 and m2 valid after grant 2 → grant 0.
